// File: rtl/feature_packer.sv
// Feature packer: serialises accepted features into 10-word packets
// (HDR, LVL, 8x DESC) on a 32-bit valid/ready stream and closes each frame
// with a two-word trailer (counts, then tag with out_last).
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   in_valid/in_ready feature handshake; in_ready only in IDLE with no frame end pending
//   in_descriptor     256-bit descriptor
//   in_feature_x/y    COORD_BITS coordinates
//   in_level          16-bit pyramid level
//   in_frame_end      single-cycle end-of-frame pulse
//   out_data/out_valid/out_last/out_ready  packed word stream
module feature_packer #(
    parameter  int unsigned COORD_BITS      = 10,
    parameter  int unsigned MAX_FEATURES    = 500,
    localparam int unsigned DESCRIPTOR_BITS = 256,
    localparam int unsigned LEVEL_BITS      = 16,
    localparam int unsigned WORD_BITS       = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [DESCRIPTOR_BITS-1:0] in_descriptor,
    input  logic [COORD_BITS-1:0]      in_feature_x,
    input  logic [COORD_BITS-1:0]      in_feature_y,
    input  logic [LEVEL_BITS-1:0]      in_level,
    output logic                       in_ready,
    input  logic                       in_frame_end,
    output logic [WORD_BITS-1:0]       out_data,
    output logic                       out_valid,
    output logic                       out_last,
    input  logic                       out_ready
);

    localparam int unsigned CNT_BITS    = 16;
    localparam int unsigned HALF_BITS   = 16;
    localparam logic [CNT_BITS-1:0]  MAX_CNT     = CNT_BITS'(MAX_FEATURES);
    localparam logic [CNT_BITS-1:0]  CNT_SAT     = 16'hFFFF;
    localparam logic [WORD_BITS-1:0] TRAILER_TAG = 32'hFEA7_E0F0;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR  = 3'd1,
        S_LVL  = 3'd2,
        S_DESC = 3'd3,
        S_TRL0 = 3'd4,
        S_TRL1 = 3'd5
    } state_t;

    state_t                     r_state, w_nxt_state;
    logic [2:0]                 r_widx, w_nxt_widx;
    logic [CNT_BITS-1:0]        r_emitted, w_nxt_emitted;
    logic [CNT_BITS-1:0]        r_dropped, w_nxt_dropped;
    logic                       r_pending, w_nxt_pending;
    logic [COORD_BITS-1:0]      r_x, w_nxt_x;
    logic [COORD_BITS-1:0]      r_y, w_nxt_y;
    logic [LEVEL_BITS-1:0]      r_lvl, w_nxt_lvl;
    logic [DESCRIPTOR_BITS-1:0] r_desc, w_nxt_desc;
    logic [WORD_BITS-1:0]       r_out_data, w_nxt_data;
    logic                       r_out_valid, w_nxt_valid;
    logic                       r_out_last, w_nxt_last;
    logic                       w_xfer;
    logic                       w_accept;

    // in_ready is gated by reset so no feature can be taken in the reset cycle
    assign in_ready  = (r_state == S_IDLE) && !r_pending && !reset;
    assign w_accept  = in_valid && in_ready;
    assign w_xfer    = r_out_valid && out_ready;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;

    // Next-state logic; output word is decoded from the next state so the
    // output registers hold stable whenever the state does.
    always_comb begin
        w_nxt_state   = r_state;
        w_nxt_widx    = r_widx;
        w_nxt_emitted = r_emitted;
        w_nxt_dropped = r_dropped;
        w_nxt_pending = r_pending | in_frame_end;
        w_nxt_x       = r_x;
        w_nxt_y       = r_y;
        w_nxt_lvl     = r_lvl;
        w_nxt_desc    = r_desc;
        w_nxt_data    = '0;
        w_nxt_valid   = 1'b0;
        w_nxt_last    = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (r_emitted < MAX_CNT) begin
                        w_nxt_x     = in_feature_x;
                        w_nxt_y     = in_feature_y;
                        w_nxt_lvl   = in_level;
                        w_nxt_desc  = in_descriptor;
                        w_nxt_state = S_HDR;
                    end else if (r_dropped != CNT_SAT) begin
                        w_nxt_dropped = r_dropped + 16'd1;
                    end
                end else if (r_pending || in_frame_end) begin
                    // Entering a trailer consumes one frame end; a second
                    // one arriving together stays pending.
                    w_nxt_state   = S_TRL0;
                    w_nxt_pending = r_pending & in_frame_end;
                end
            end
            S_HDR: begin
                if (w_xfer) w_nxt_state = S_LVL;
            end
            S_LVL: begin
                if (w_xfer) begin
                    w_nxt_state   = S_DESC;
                    w_nxt_widx    = 3'd0;
                    w_nxt_emitted = r_emitted + 16'd1;
                end
            end
            S_DESC: begin
                if (w_xfer) begin
                    if (r_widx == 3'd7) begin
                        if (r_pending || in_frame_end) begin
                            w_nxt_state   = S_TRL0;
                            w_nxt_pending = r_pending & in_frame_end;
                        end else begin
                            w_nxt_state = S_IDLE;
                        end
                    end else begin
                        w_nxt_widx = r_widx + 3'd1;
                    end
                end
            end
            S_TRL0: begin
                if (w_xfer) w_nxt_state = S_TRL1;
            end
            S_TRL1: begin
                if (w_xfer) begin
                    w_nxt_state   = S_IDLE;
                    w_nxt_emitted = '0;
                    w_nxt_dropped = '0;
                end
            end
            default: w_nxt_state = S_IDLE;
        endcase

        // Output word for the state about to be entered
        w_nxt_valid = (w_nxt_state != S_IDLE);
        w_nxt_last  = (w_nxt_state == S_TRL1);
        case (w_nxt_state)
            S_HDR:   w_nxt_data = {HALF_BITS'(w_nxt_x), HALF_BITS'(w_nxt_y)};
            S_LVL:   w_nxt_data = {w_nxt_lvl, w_nxt_emitted};
            S_DESC:  w_nxt_data = w_nxt_desc[{w_nxt_widx, 5'd0} +: WORD_BITS];
            S_TRL0:  w_nxt_data = {w_nxt_emitted, w_nxt_dropped};
            S_TRL1:  w_nxt_data = TRAILER_TAG;
            default: w_nxt_data = '0;
        endcase
    end

    // Control and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_widx      <= '0;
            r_emitted   <= '0;
            r_dropped   <= '0;
            r_pending   <= 1'b0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            r_state     <= w_nxt_state;
            r_widx      <= w_nxt_widx;
            r_emitted   <= w_nxt_emitted;
            r_dropped   <= w_nxt_dropped;
            r_pending   <= w_nxt_pending;
            r_out_data  <= w_nxt_data;
            r_out_valid <= w_nxt_valid;
            r_out_last  <= w_nxt_last;
        end
    end

    // Feature holding register; contents after reset are irrelevant
    always_ff @(posedge clk) begin
        r_x    <= w_nxt_x;
        r_y    <= w_nxt_y;
        r_lvl  <= w_nxt_lvl;
        r_desc <= w_nxt_desc;
    end

endmodule

// File: tb/tb_feature_packer.sv
// Directed bench for feature_packer: default-parameter instance plus a
// MAX_FEATURES=2 instance sharing the stimulus; 'sel' picks which is observed.
module tb_feature_packer;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic [255:0] in_descriptor;
    logic [9:0]   in_feature_x;
    logic [9:0]   in_feature_y;
    logic [15:0]  in_level;
    logic         in_frame_end;
    logic         out_ready;

    logic         ir_a, ov_a, ol_a, ir_b, ov_b, ol_b;
    logic [31:0]  od_a, od_b;
    logic         sel;
    logic         ir, ov, ol;
    logic [31:0]  od;

    int checks   = 0;
    int failures = 0;
    logic [31:0] got_d[$];
    logic        got_l[$];
    int stall_bad;
    int ir_low;

    feature_packer dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_descriptor(in_descriptor),
        .in_feature_x(in_feature_x), .in_feature_y(in_feature_y), .in_level(in_level),
        .in_ready(ir_a), .in_frame_end(in_frame_end), .out_data(od_a),
        .out_valid(ov_a), .out_last(ol_a), .out_ready(out_ready)
    );

    feature_packer #(.COORD_BITS(10), .MAX_FEATURES(2)) dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_descriptor(in_descriptor),
        .in_feature_x(in_feature_x), .in_feature_y(in_feature_y), .in_level(in_level),
        .in_ready(ir_b), .in_frame_end(in_frame_end), .out_data(od_b),
        .out_valid(ov_b), .out_last(ol_b), .out_ready(out_ready)
    );

    assign ir = sel ? ir_b : ir_a;
    assign ov = sel ? ov_b : ov_a;
    assign ol = sel ? ol_b : ol_a;
    assign od = sel ? od_b : od_a;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] exp_word(input int k, input logic [9:0] x, input logic [9:0] y,
                                             input logic [15:0] lvl, input logic [15:0] seq,
                                             input logic [255:0] d);
        if (k == 0) return {6'd0, x, 6'd0, y};
        if (k == 1) return {lvl, seq};
        return d[32*(k-2) +: 32];
    endfunction

    function automatic logic [255:0] rand_desc();
        logic [255:0] d;
        for (int j = 0; j < 8; j++) d[32*j +: 32] = $urandom();
        return d;
    endfunction

    function automatic logic [255:0] ramp_desc();
        logic [255:0] d;
        for (int j = 0; j < 8; j++) d[32*j +: 32] = 32'(j);
        return d;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; in_valid = 1'b0; in_frame_end = 1'b0; out_ready = 1'b1;
        step(); step();
        reset = 1'b0;
        step();
    endtask

    task automatic send(input logic [9:0] x, input logic [9:0] y, input logic [15:0] l,
                        input logic [255:0] d);
        int n;
        n = 0;
        while (!ir && n < 200) begin step(); n++; end
        if (n >= 200) begin
            checks++; failures++;
            $display("FAIL send_timeout in_ready=%b want=1", ir);
        end
        in_valid = 1'b1; in_feature_x = x; in_feature_y = y; in_level = l; in_descriptor = d;
        step();
        in_valid = 1'b0;
    endtask

    task automatic pulse_fe();
        in_frame_end = 1'b1;
        step();
        in_frame_end = 1'b0;
    endtask

    // Gather n transferred words; with rnd, out_ready is randomised
    task automatic collect(input int n, input bit rnd);
        int          cyc;
        bit          stalled;
        logic [31:0] pd;
        cyc = 0; stalled = 0; pd = '0;
        got_d.delete(); got_l.delete(); stall_bad = 0; ir_low = 0;
        while (got_d.size() < n && cyc < n * 20 + 50) begin
            if (stalled && (!ov || od !== pd)) stall_bad++;
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (!ir) ir_low++;
            if (ov && out_ready) begin got_d.push_back(od); got_l.push_back(ol); end
            stalled = ov && !out_ready;
            pd = od;
            step();
            cyc++;
        end
        out_ready = 1'b1;
        if (got_d.size() < n) begin
            checks++; failures++;
            $display("FAIL collect_timeout words=%0d want=%0d", got_d.size(), n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; in_frame_end = 1'b0; out_ready = 1'b1;
        in_descriptor = '0; in_feature_x = '0; in_feature_y = '0; in_level = '0;
        step(); step();
        checks++;
        if (ir !== 1'b0 || ov !== 1'b0 || ol !== 1'b0 || od !== 32'h0) begin
            failures++;
            $display("FAIL reset_cycle ir=%b ov=%b ol=%b od=%h want 0/0/0/0", ir, ov, ol, od);
        end
        reset = 1'b0;
        step();
        checks++;
        if (ir !== 1'b1 || ov !== 1'b0 || od !== 32'h0) begin
            failures++;
            $display("FAIL after_reset ir=%b ov=%b od=%h want 1/0/0", ir, ov, od);
        end
    endtask

    task automatic test_single();
        logic [31:0] exp_w [10];
        do_reset();
        exp_w[0] = 32'h0005_0007;
        exp_w[1] = 32'h0003_0000;
        for (int k = 0; k < 8; k++) exp_w[k+2] = 32'(k);
        send(10'd5, 10'd7, 16'd3, ramp_desc());
        collect(10, 1'b0);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (got_d[i] !== exp_w[i] || got_l[i] !== 1'b0) begin
                failures++;
                $display("FAIL single_w%0d got=%h last=%b want=%h last=0", i, got_d[i], got_l[i], exp_w[i]);
            end
        end
        checks++;
        if (ir_low !== 10 || ir !== 1'b1 || ov !== 1'b0) begin
            failures++;
            $display("FAIL single_in_ready low=%0d ir=%b ov=%b want 10/1/0", ir_low, ir, ov);
        end
    endtask

    task automatic test_frame3();
        logic [255:0] d;
        logic [9:0]   x, y;
        logic [15:0]  l;
        do_reset();
        for (int f = 0; f < 3; f++) begin
            d = rand_desc(); x = 10'($urandom); y = 10'($urandom); l = 16'($urandom);
            send(x, y, l, d);
            collect(10, 1'b0);
            for (int i = 0; i < 10; i++) begin
                checks++;
                if (got_d[i] !== exp_word(i, x, y, l, 16'(f), d) || got_l[i] !== 1'b0) begin
                    failures++;
                    $display("FAIL frame3_p%0d_w%0d got=%h want=%h", f, i, got_d[i], exp_word(i, x, y, l, 16'(f), d));
                end
            end
        end
        pulse_fe();
        collect(2, 1'b0);
        checks++;
        if (got_d[0] !== 32'h0003_0000 || got_l[0] !== 1'b0) begin
            failures++;
            $display("FAIL frame3_trl0 got=%h last=%b want=00030000 last=0", got_d[0], got_l[0]);
        end
        checks++;
        if (got_d[1] !== 32'hFEA7_E0F0 || got_l[1] !== 1'b1) begin
            failures++;
            $display("FAIL frame3_trl1 got=%h last=%b want=fea7e0f0 last=1", got_d[1], got_l[1]);
        end
        send(10'd1, 10'd2, 16'h00AA, ramp_desc());
        collect(10, 1'b0);
        checks++;
        if (got_d[1] !== 32'h00AA_0000) begin
            failures++;
            $display("FAIL next_frame_seq got=%h want=00aa0000", got_d[1]);
        end
    endtask

    task automatic test_max();
        logic [255:0] d;
        logic [9:0]   x, y;
        logic [15:0]  l;
        sel = 1'b1;
        do_reset();
        for (int f = 0; f < 2; f++) begin
            d = rand_desc(); x = 10'($urandom); y = 10'($urandom); l = 16'($urandom);
            send(x, y, l, d);
            collect(10, 1'b0);
            for (int i = 0; i < 10; i++) begin
                checks++;
                if (got_d[i] !== exp_word(i, x, y, l, 16'(f), d)) begin
                    failures++;
                    $display("FAIL max_p%0d_w%0d got=%h want=%h", f, i, got_d[i], exp_word(i, x, y, l, 16'(f), d));
                end
            end
        end
        for (int f = 0; f < 2; f++) begin
            send(10'd9, 10'd9, 16'd9, rand_desc());
            checks++;
            if (ov !== 1'b0 || ir !== 1'b1) begin
                failures++;
                $display("FAIL max_drop%0d ov=%b ir=%b want 0/1", f, ov, ir);
            end
        end
        pulse_fe();
        collect(2, 1'b0);
        checks++;
        if (got_d[0] !== 32'h0002_0002 || got_d[1] !== 32'hFEA7_E0F0 || got_l[1] !== 1'b1) begin
            failures++;
            $display("FAIL max_trailer got=%h,%h want=00020002,fea7e0f0", got_d[0], got_d[1]);
        end
        sel = 1'b0;
    endtask

    task automatic test_coincident();
        logic [255:0] d;
        d = rand_desc();
        do_reset();
        in_valid = 1'b1; in_frame_end = 1'b1;
        in_feature_x = 10'h3FF; in_feature_y = 10'h001; in_level = 16'h0102; in_descriptor = d;
        step();
        in_valid = 1'b0; in_frame_end = 1'b0;
        collect(12, 1'b0);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (got_d[i] !== exp_word(i, 10'h3FF, 10'h001, 16'h0102, 16'd0, d) || got_l[i] !== 1'b0) begin
                failures++;
                $display("FAIL coinc_w%0d got=%h want=%h", i, got_d[i], exp_word(i, 10'h3FF, 10'h001, 16'h0102, 16'd0, d));
            end
        end
        checks++;
        if (got_d[10] !== 32'h0001_0000 || got_d[11] !== 32'hFEA7_E0F0 || got_l[10] !== 1'b0 || got_l[11] !== 1'b1) begin
            failures++;
            $display("FAIL coinc_trailer got=%h,%h want=00010000,fea7e0f0", got_d[10], got_d[11]);
        end
    endtask

    task automatic test_stall();
        logic [255:0] d;
        logic [9:0]   x, y;
        logic [15:0]  l;
        int           bad;
        bad = 0;
        do_reset();
        for (int f = 0; f < 3; f++) begin
            d = rand_desc(); x = 10'($urandom); y = 10'($urandom); l = 16'($urandom);
            send(x, y, l, d);
            collect(10, 1'b1);
            bad += stall_bad;
            for (int i = 0; i < 10; i++) begin
                checks++;
                if (got_d[i] !== exp_word(i, x, y, l, 16'(f), d)) begin
                    failures++;
                    $display("FAIL stall_p%0d_w%0d got=%h want=%h", f, i, got_d[i], exp_word(i, x, y, l, 16'(f), d));
                end
            end
        end
        pulse_fe();
        collect(2, 1'b1);
        bad += stall_bad;
        checks++;
        if (got_d[0] !== 32'h0003_0000 || got_d[1] !== 32'hFEA7_E0F0 || got_l[1] !== 1'b1) begin
            failures++;
            $display("FAIL stall_trailer got=%h,%h want=00030000,fea7e0f0", got_d[0], got_d[1]);
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL stall_stable unstable_cycles=%0d want=0", bad);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        send(10'd5, 10'd7, 16'd3, ramp_desc());
        collect(6, 1'b0);
        checks++;
        if (ov !== 1'b1 || od !== 32'h0000_0004) begin
            failures++;
            $display("FAIL mid_desc4 ov=%b od=%h want 1/00000004", ov, od);
        end
        reset = 1'b1;
        step();
        checks++;
        if (ov !== 1'b0 || ir !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset ov=%b ir=%b want 0/0", ov, ir);
        end
        reset = 1'b0;
        step();
        checks++;
        if (ov !== 1'b0 || ir !== 1'b1) begin
            failures++;
            $display("FAIL mid_after ov=%b ir=%b want 0/1", ov, ir);
        end
        pulse_fe();
        collect(2, 1'b0);
        checks++;
        if (got_d[0] !== 32'h0000_0000 || got_d[1] !== 32'hFEA7_E0F0 || got_l[1] !== 1'b1) begin
            failures++;
            $display("FAIL mid_trailer got=%h,%h want=00000000,fea7e0f0", got_d[0], got_d[1]);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        pulse_fe();
        checks++;
        if (ov !== 1'b1 || od !== 32'h0 || ol !== 1'b0) begin
            failures++;
            $display("FAIL b2b_trl0 ov=%b od=%h ol=%b want 1/00000000/0", ov, od, ol);
        end
        in_frame_end = 1'b1;
        step();
        in_frame_end = 1'b0;
        collect(3, 1'b0);
        checks++;
        if (got_d[0] !== 32'hFEA7_E0F0 || got_l[0] !== 1'b1 ||
            got_d[1] !== 32'h0000_0000 || got_l[1] !== 1'b0 ||
            got_d[2] !== 32'hFEA7_E0F0 || got_l[2] !== 1'b1) begin
            failures++;
            $display("FAIL b2b_second_trailer got=%h,%h,%h want=fea7e0f0,00000000,fea7e0f0",
                     got_d[0], got_d[1], got_d[2]);
        end
    endtask

    initial begin
        sel = 1'b0;
        test_reset();
        test_single();
        test_frame3();
        test_max();
        test_coincident();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
